// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit universal shift register with enable and a registered carry.
//   Supports hold, logical shift left/right with serial inputs, parallel load,
//   rotate left/right, arithmetic shift right and clear. Every operation lands
//   on the same rising edge where its controls are sampled.
//
// Parameters
//   WIDTH        register width, 1..64
//   RESET_VALUE  value loaded into q on reset
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset (wins over en/mode)
//   en       in   operation enable; 0 holds q and carry for any mode
//   mode     in   operation select (3 bits)
//   d        in   parallel load data
//   sin_lsb  in   serial bit entering bit 0 on SHL
//   sin_msb  in   serial bit entering bit WIDTH-1 on SHR
//   q        out  registered register contents
//   carry    out  registered last bit shifted/rotated out
//   zero     out  combinational, 1 when q == 0
//   so_msb   out  combinational copy of q[WIDTH-1]
//   so_lsb   out  combinational copy of q[0]
// -----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero,
    output logic             so_msb,
    output logic             so_lsb
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ASHR  = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] lsb_ins;
    logic [WIDTH-1:0] msb_ins;

    assign op = mode_e'(mode);

    // Shifts are written as whole-vector shifts plus single-bit inserts so the
    // same expressions stay legal and correct at WIDTH=1 (no [WIDTH-2:0] slice).
    always_comb begin
        data_d             = data_q;
        carry_d            = carry_q;
        lsb_ins            = '0;
        lsb_ins[0]         = sin_lsb;
        msb_ins            = '0;
        msb_ins[WIDTH-1]   = sin_msb;

        if (en) begin
            case (op)
                MODE_HOLD: begin
                    data_d  = data_q;
                    carry_d = carry_q;
                end
                MODE_SHL: begin
                    data_d  = (data_q << 1) | lsb_ins;
                    carry_d = data_q[WIDTH-1];
                end
                MODE_SHR: begin
                    data_d  = (data_q >> 1) | msb_ins;
                    carry_d = data_q[0];
                end
                MODE_LOAD: begin
                    data_d  = d;
                    carry_d = 1'b0;
                end
                MODE_ROTL: begin
                    data_d  = (data_q << 1) | (data_q >> (WIDTH - 1));
                    carry_d = data_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    data_d  = (data_q >> 1) | (data_q << (WIDTH - 1));
                    carry_d = data_q[0];
                end
                MODE_ASHR: begin
                    data_d          = data_q >> 1;
                    data_d[WIDTH-1] = data_q[WIDTH-1];
                    carry_d         = data_q[0];
                end
                MODE_CLEAR: begin
                    data_d  = '0;
                    carry_d = 1'b0;
                end
                default: begin
                    data_d  = data_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign q      = data_q;
    assign carry  = carry_q;
    assign zero   = (data_q == '0);
    assign so_msb = data_q[WIDTH-1];
    assign so_lsb = data_q[0];

endmodule
